// File: rtl/counter_pkg.sv
// Shared defaults for the modulo-N counter family.
// Instances that need a different modulus override the parameters at instantiation.
`timescale 1ns/1ps
package counter_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_MAX   = 255;

endpackage

// File: rtl/mod_counter.sv
// Free-running modulo-(MAX_VAL+1) up-counter with a registered carry-out.
// O_cout is high for exactly the cycle in which O_cnt sits at MAX_VAL.
`timescale 1ns/1ps
module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MAX_VAL = DEFAULT_MAX
) (
    input  logic             I_clk,
    input  logic             I_rst,
    output logic [WIDTH-1:0] O_cnt,
    output logic             O_cout
);

    localparam logic [WIDTH-1:0] TERMINAL = WIDTH'(MAX_VAL);

    generate
        if (MAX_VAL < 1 || longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
            $error("mod_counter: MAX_VAL=%0d outside 1..2**WIDTH-1 for WIDTH=%0d", MAX_VAL, WIDTH);
        end
    endgenerate

    // Wrap is an explicit compare, so non-power-of-two moduli never overflow.
    logic [WIDTH-1:0] cnt_next;
    assign cnt_next = (O_cnt == TERMINAL) ? '0 : O_cnt + WIDTH'(1);

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            O_cnt <= '0;
        end else begin
            O_cnt <= cnt_next;
        end
    end

    // Carry is registered from the next count so it lines up with O_cnt==MAX_VAL.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            O_cout <= 1'b0;
        end else begin
            O_cout <= (cnt_next == TERMINAL);
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: a default 8-bit/255 instance and a 4-bit/9 instance
// share clock and reset and are compared every cycle against an arithmetic modulo model.
`timescale 1ns/1ps
module tb_mod_counter;

    localparam int BIG_MAX   = 255;
    localparam int SMALL_MAX = 9;

    logic       clk;
    logic       rst;
    logic [7:0] big_cnt;
    logic       big_cout;
    logic [3:0] small_cnt;
    logic       small_cout;

    int checks   = 0;
    int failures = 0;

    int cycle        = 0;
    int big_exp      = 0;
    int small_exp    = 0;
    int big_rise     = -1;
    int small_rise   = -1;
    logic big_prev   = 1'b0;
    logic small_prev = 1'b0;

    mod_counter u_big (
        .I_clk  (clk),
        .I_rst  (rst),
        .O_cnt  (big_cnt),
        .O_cout (big_cout)
    );

    mod_counter #(.WIDTH(4), .MAX_VAL(SMALL_MAX)) u_small (
        .I_clk  (clk),
        .I_rst  (rst),
        .O_cnt  (small_cnt),
        .O_cout (small_cout)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    task automatic check_value(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // One clock edge with the given reset level; model advances, then both DUTs are compared.
    task automatic tick(input logic r);
        rst = r;
        @(posedge clk);
        cycle++;
        big_exp   = r ? 0 : (big_exp + 1) % (BIG_MAX + 1);
        small_exp = r ? 0 : (small_exp + 1) % (SMALL_MAX + 1);
        #0.5;
        check_value("big_cnt", int'(big_cnt), big_exp);
        check_value("big_cout", int'(big_cout), (!r && big_exp == BIG_MAX) ? 1 : 0);
        check_value("small_cnt", int'(small_cnt), small_exp);
        check_value("small_cout", int'(small_cout), (!r && small_exp == SMALL_MAX) ? 1 : 0);
        check_value("small_range", (int'(small_cnt) <= SMALL_MAX) ? 1 : 0, 1);
        if (r) begin
            big_rise   = -1;
            small_rise = -1;
        end
        if (big_cout === 1'b1 && big_prev === 1'b0) begin
            if (big_rise >= 0) check_value("big_period", cycle - big_rise, BIG_MAX + 1);
            big_rise = cycle;
        end
        if (small_cout === 1'b1 && small_prev === 1'b0) begin
            if (small_rise >= 0) check_value("small_period", cycle - small_rise, SMALL_MAX + 1);
            small_rise = cycle;
        end
        big_prev   = big_cout;
        small_prev = small_cout;
    endtask

    // Count freely until the default counter model reaches target; a missed target is a failure.
    task automatic run_to(input int target, input string tag);
        int budget;
        budget = 0;
        while (big_exp != target && budget < 2 * (BIG_MAX + 1)) begin
            tick(1'b0);
            budget++;
        end
        check_value(tag, big_exp, target);
    endtask

    initial begin
        rst = 1'b1;

        // Reset held for several edges: count and carry stay at zero.
        for (int i = 0; i < 4; i++) tick(1'b1);

        // Free run through more than two full periods of the default counter.
        for (int i = 0; i < 600; i++) tick(1'b0);

        // Mid-count reset at 100, then counting resumes from 1.
        run_to(100, "reach_100");
        tick(1'b1);
        check_value("mid_reset_cnt", int'(big_cnt), 0);
        check_value("mid_reset_cout", int'(big_cout), 0);
        for (int i = 0; i < 5; i++) tick(1'b0);
        check_value("resume_cnt", int'(big_cnt), 5);

        // Reset at 254 beats the carry that would have fired on this edge.
        run_to(254, "reach_254");
        tick(1'b1);
        check_value("term_reset_cnt", int'(big_cnt), 0);
        check_value("term_reset_cout", int'(big_cout), 0);

        // Random reset pulses mixed into long runs.
        for (int i = 0; i < 3000; i++) tick($urandom_range(0, 63) == 0);

        // Finish with a clean run so periods are measured after the random phase.
        for (int i = 0; i < 520; i++) tick(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
